// File: rtl/cv_xif_mem_pkg.sv
// cv_xif_mem_pkg: shared constants and types for the CV-X-IF memory responder.
//   EXC_*_MISALIGNED  : exception codes returned on a misaligned request
//   xif_mem_entry_t   : outstanding-transaction record {hartid, id, we} at the
//                       default widths; the top packs entries in this bit order
//   is_misaligned()   : alignment rule shared by the responder
package cv_xif_mem_pkg;

  localparam int X_ID_WIDTH_DEF     = 4;
  localparam int X_HARTID_WIDTH_DEF = 1;

  localparam logic [5:0] EXC_LOAD_MISALIGNED  = 6'd4;
  localparam logic [5:0] EXC_STORE_MISALIGNED = 6'd6;

  typedef struct packed {
    logic [X_HARTID_WIDTH_DEF-1:0] hartid;
    logic [X_ID_WIDTH_DEF-1:0]     id;
    logic                          we;
  } xif_mem_entry_t;

  // Sizes above word are never legal on a 32-bit bus.
  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return ((size == 3'd1) && addr_lo[0]) ||
           ((size == 3'd2) && (addr_lo != 2'b00)) ||
           (size > 3'd2);
  endfunction

endpackage

// File: rtl/cv_xif_mem_fifo.sv
// cv_xif_mem_fifo: synchronous FIFO tracking outstanding bus transactions.
//   clk_i, rst_i      : clock, synchronous active-high reset (empties the FIFO)
//   push_i, wdata_i   : enqueue (ignored when full)
//   pop_i, head_o     : dequeue (ignored when empty) / current head entry
//   full_o, empty_o   : derived from the registered count
//   count_o           : registered occupancy, $clog2(DEPTH+1) bits
module cv_xif_mem_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 6
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           push_i,
  input  logic [WIDTH-1:0]               wdata_i,
  input  logic                           pop_i,
  output logic [WIDTH-1:0]               head_o,
  output logic                           full_o,
  output logic                           empty_o,
  output logic [$clog2(DEPTH+1)-1:0]     count_o
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wptr_q, rptr_q;
  logic             do_push, do_pop;

  // Pointers wrap modulo DEPTH, so non-power-of-two depths work too.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_o == CW'(DEPTH));
  assign empty_o = (count_o == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rptr_q];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_o <= '0;
    end else begin
      if (do_push) wptr_q <= next_ptr(wptr_q);
      if (do_pop)  rptr_q <= next_ptr(rptr_q);
      case ({do_push, do_pop})
        2'b10:   count_o <= count_o + 1'b1;
        2'b01:   count_o <= count_o - 1'b1;
        default: count_o <= count_o;
      endcase
    end
  end

  // Payload storage needs no reset: only entries below count are ever read.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cv_xif_mem_responder.sv
// cv_xif_mem_responder: CPU-side responder for CV-X-IF mem / mem_result.
//   Checks alignment of coprocessor requests, forwards legal ones to the
//   OBI data bus, tracks outstanding transactions in order and returns
//   mem_result tagged with the originating id/hartid.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-high reset
//   mem_*_i / mem_*_o  : CV-X-IF memory request / same-cycle response
//   mem_result_*_o     : CV-X-IF memory result (single-cycle pulse, no ready)
//   data_*             : OBI address phase (req/gnt) and response phase (rvalid)
// Configuration:
//   CV_XIF_MEM_RESULT_REG_EN defined   -> mem_result_* registered, 1-cycle latency
//   CV_XIF_MEM_RESULT_REG_EN undefined -> mem_result_* combinational, 0-cycle latency
module cv_xif_mem_responder
  import cv_xif_mem_pkg::*;
#(
  parameter int X_ID_WIDTH     = 4,
  parameter int X_HARTID_WIDTH = 1,
  parameter int X_MEM_WIDTH    = 32,
  parameter int DEPTH          = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      mem_valid_i,
  output logic                      mem_ready_o,
  input  logic [X_ID_WIDTH-1:0]     mem_id_i,
  input  logic [X_HARTID_WIDTH-1:0] mem_hartid_i,
  input  logic [31:0]               mem_addr_i,
  input  logic                      mem_we_i,
  input  logic [2:0]                mem_size_i,
  input  logic [X_MEM_WIDTH/8-1:0]  mem_be_i,
  input  logic [X_MEM_WIDTH-1:0]    mem_wdata_i,
  output logic                      mem_exc_o,
  output logic [5:0]                mem_exccode_o,
  output logic                      mem_dbg_o,
  output logic                      mem_result_valid_o,
  output logic [X_ID_WIDTH-1:0]     mem_result_id_o,
  output logic [X_HARTID_WIDTH-1:0] mem_result_hartid_o,
  output logic [X_MEM_WIDTH-1:0]    mem_result_rdata_o,
  output logic                      mem_result_err_o,
  output logic                      mem_result_dbg_o,
  output logic                      data_req_o,
  input  logic                      data_gnt_i,
  output logic [31:0]               data_addr_o,
  output logic                      data_we_o,
  output logic [X_MEM_WIDTH/8-1:0]  data_be_o,
  output logic [X_MEM_WIDTH-1:0]    data_wdata_o,
  input  logic                      data_rvalid_i,
  input  logic [X_MEM_WIDTH-1:0]    data_rdata_i,
  input  logic                      data_err_i
);

  // Entry layout matches xif_mem_entry_t: {hartid, id, we}.
  localparam int EW = X_HARTID_WIDTH + X_ID_WIDTH + 1;

  logic                        misaligned, full, empty, push, pop;
  logic [EW-1:0]               head;
  logic [$clog2(DEPTH+1)-1:0]  count;
  logic                        head_we;
  logic [X_ID_WIDTH-1:0]       head_id;
  logic [X_HARTID_WIDTH-1:0]   head_hartid;

  // Result values as seen in the rvalid cycle, before optional registering.
  logic                        res_valid, res_err;
  logic [X_ID_WIDTH-1:0]       res_id;
  logic [X_HARTID_WIDTH-1:0]   res_hartid;
  logic [X_MEM_WIDTH-1:0]      res_rdata;

  assign misaligned = is_misaligned(mem_size_i, mem_addr_i[1:0]);

  // full comes from the registered count, so a same-cycle pop never frees a
  // slot for the request presented in that cycle.
  assign data_req_o    = mem_valid_i && !misaligned && !full;
  assign push          = data_req_o && data_gnt_i;
  assign mem_exc_o     = mem_valid_i && misaligned;
  assign mem_ready_o   = mem_exc_o || push;
  assign mem_exccode_o = mem_exc_o ? (mem_we_i ? EXC_STORE_MISALIGNED : EXC_LOAD_MISALIGNED) : 6'd0;
  assign mem_dbg_o     = 1'b0;

  assign data_addr_o  = data_req_o ? mem_addr_i  : '0;
  assign data_we_o    = data_req_o ? mem_we_i    : 1'b0;
  assign data_be_o    = data_req_o ? mem_be_i    : '0;
  assign data_wdata_o = data_req_o ? mem_wdata_i : '0;

  // rvalid with nothing outstanding is dropped here.
  assign pop = data_rvalid_i && !empty;

  cv_xif_mem_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push),
    .wdata_i ({mem_hartid_i, mem_id_i, mem_we_i}),
    .pop_i   (pop),
    .head_o  (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );

  assign head_we     = head[0];
  assign head_id     = head[X_ID_WIDTH:1];
  assign head_hartid = head[EW-1 -: X_HARTID_WIDTH];

  assign res_valid  = pop;
  assign res_id     = pop ? head_id     : '0;
  assign res_hartid = pop ? head_hartid : '0;
  assign res_rdata  = (pop && !head_we) ? data_rdata_i : '0;
  assign res_err    = pop && data_err_i;

`ifdef CV_XIF_MEM_RESULT_REG_EN
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_result_valid_o  <= 1'b0;
      mem_result_id_o     <= '0;
      mem_result_hartid_o <= '0;
      mem_result_rdata_o  <= '0;
      mem_result_err_o    <= 1'b0;
    end else begin
      mem_result_valid_o  <= res_valid;
      mem_result_id_o     <= res_id;
      mem_result_hartid_o <= res_hartid;
      mem_result_rdata_o  <= res_rdata;
      mem_result_err_o    <= res_err;
    end
  end
`else
  assign mem_result_valid_o  = res_valid;
  assign mem_result_id_o     = res_id;
  assign mem_result_hartid_o = res_hartid;
  assign mem_result_rdata_o  = res_rdata;
  assign mem_result_err_o    = res_err;
`endif

  assign mem_result_dbg_o = 1'b0;

  // Bus protocol violation: a response with nothing outstanding. Reported,
  // not fatal, since the block recovers by ignoring it.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      assert (!(data_rvalid_i && (count == '0)))
        else $warning("cv_xif_mem_responder: data_rvalid_i with no outstanding transaction");
    end
  end

endmodule

// File: tb/tb_cv_xif_mem_responder.sv
// tb_cv_xif_mem_responder: directed scenarios plus randomized traffic, checked
// every cycle against a queue-based reference model of the responder.
module tb_cv_xif_mem_responder;
  import cv_xif_mem_pkg::*;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        mem_valid_i, mem_ready_o;
  logic [3:0]  mem_id_i;
  logic [0:0]  mem_hartid_i;
  logic [31:0] mem_addr_i;
  logic        mem_we_i;
  logic [2:0]  mem_size_i;
  logic [3:0]  mem_be_i;
  logic [31:0] mem_wdata_i;
  logic        mem_exc_o;
  logic [5:0]  mem_exccode_o;
  logic        mem_dbg_o;
  logic        mem_result_valid_o;
  logic [3:0]  mem_result_id_o;
  logic [0:0]  mem_result_hartid_o;
  logic [31:0] mem_result_rdata_o;
  logic        mem_result_err_o, mem_result_dbg_o;
  logic        data_req_o, data_gnt_i;
  logic [31:0] data_addr_o;
  logic        data_we_o;
  logic [3:0]  data_be_o;
  logic [31:0] data_wdata_o;
  logic        data_rvalid_i;
  logic [31:0] data_rdata_i;
  logic        data_err_i;

  cv_xif_mem_responder #(
    .X_ID_WIDTH(4), .X_HARTID_WIDTH(1), .X_MEM_WIDTH(32), .DEPTH(DEPTH)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
    .mem_id_i(mem_id_i), .mem_hartid_i(mem_hartid_i), .mem_addr_i(mem_addr_i),
    .mem_we_i(mem_we_i), .mem_size_i(mem_size_i), .mem_be_i(mem_be_i),
    .mem_wdata_i(mem_wdata_i),
    .mem_exc_o(mem_exc_o), .mem_exccode_o(mem_exccode_o), .mem_dbg_o(mem_dbg_o),
    .mem_result_valid_o(mem_result_valid_o), .mem_result_id_o(mem_result_id_o),
    .mem_result_hartid_o(mem_result_hartid_o), .mem_result_rdata_o(mem_result_rdata_o),
    .mem_result_err_o(mem_result_err_o), .mem_result_dbg_o(mem_result_dbg_o),
    .data_req_o(data_req_o), .data_gnt_i(data_gnt_i), .data_addr_o(data_addr_o),
    .data_we_o(data_we_o), .data_be_o(data_be_o), .data_wdata_o(data_wdata_o),
    .data_rvalid_i(data_rvalid_i), .data_rdata_i(data_rdata_i), .data_err_i(data_err_i)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: in-order queue of outstanding transactions.
  xif_mem_entry_t outstanding[$];
  // Result expected on the outputs (current cycle, or the previous one when registered).
  logic        r_vld, r_err;
  logic [3:0]  r_id;
  logic [0:0]  r_hart;
  logic [31:0] r_rdata;
  logic        last_rdy;
  int          results_seen;

  task automatic clear_model();
    outstanding.delete();
    r_vld = 1'b0; r_err = 1'b0; r_id = '0; r_hart = '0; r_rdata = '0;
    last_rdy = 1'b0;
  endtask

  // One clock cycle: inputs are already applied; check outputs, advance model.
  task automatic step();
    logic mis, can_issue, exp_req, exp_rdy, exp_exc, do_pop;
    logic [5:0] exp_code;
    logic        c_vld, c_err;
    logic [3:0]  c_id;
    logic [0:0]  c_hart;
    logic [31:0] c_rdata;
    xif_mem_entry_t e;
    #1;
    mis = (mem_size_i == 3'd1 && mem_addr_i[0] == 1'b1) ||
          (mem_size_i == 3'd2 && mem_addr_i[1:0] != 2'b00) ||
          (mem_size_i > 3'd2);
    can_issue = outstanding.size() < DEPTH;
    exp_req  = mem_valid_i && !mis && can_issue;
    exp_exc  = mem_valid_i && mis;
    exp_rdy  = exp_exc || (exp_req && data_gnt_i);
    exp_code = !exp_exc ? 6'd0 : (mem_we_i ? 6'd6 : 6'd4);

    do_pop  = data_rvalid_i && outstanding.size() > 0;
    c_vld = do_pop; c_id = '0; c_hart = '0; c_rdata = '0; c_err = 1'b0;
    if (do_pop) begin
      e = outstanding[0];
      c_id = e.id; c_hart = e.hartid; c_err = data_err_i;
      c_rdata = e.we ? 32'd0 : data_rdata_i;
    end
`ifndef CV_XIF_MEM_RESULT_REG_EN
    r_vld = c_vld; r_id = c_id; r_hart = c_hart; r_rdata = c_rdata; r_err = c_err;
`endif

    chk("mem_ready", mem_ready_o, exp_rdy);
    chk("mem_exc", mem_exc_o, exp_exc);
    if (exp_exc) chk("mem_exccode", mem_exccode_o, exp_code);
    chk("mem_dbg", mem_dbg_o, 0);
    chk("data_req", data_req_o, exp_req);
    chk("data_addr", data_addr_o, exp_req ? mem_addr_i : 32'd0);
    chk("data_we", data_we_o, exp_req ? mem_we_i : 1'b0);
    chk("data_be", data_be_o, exp_req ? mem_be_i : 4'd0);
    chk("data_wdata", data_wdata_o, exp_req ? mem_wdata_i : 32'd0);
    chk("res_valid", mem_result_valid_o, r_vld);
    chk("res_id", mem_result_id_o, r_id);
    chk("res_hartid", mem_result_hartid_o, r_hart);
    chk("res_rdata", mem_result_rdata_o, r_rdata);
    chk("res_err", mem_result_err_o, r_err);
    chk("res_dbg", mem_result_dbg_o, 0);
    if (mem_result_valid_o) results_seen++;

    if (do_pop) void'(outstanding.pop_front());
    if (exp_req && data_gnt_i) begin
      e.id = mem_id_i; e.hartid = mem_hartid_i; e.we = mem_we_i;
      outstanding.push_back(e);
    end
`ifdef CV_XIF_MEM_RESULT_REG_EN
    r_vld = c_vld; r_id = c_id; r_hart = c_hart; r_rdata = c_rdata; r_err = c_err;
`endif
    last_rdy = exp_rdy;
    @(posedge clk_i); #1;
  endtask

  task automatic set_req(input logic v, input logic [3:0] id, input logic [31:0] addr,
                         input logic we, input logic [2:0] size);
    mem_valid_i = v; mem_id_i = id; mem_addr_i = addr; mem_we_i = we; mem_size_i = size;
    mem_hartid_i = id[0]; mem_be_i = 4'hF; mem_wdata_i = {8'hA5, 20'h0, id};
  endtask

  task automatic idle_bus();
    data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0; data_err_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    set_req(1'b0, 4'd0, 32'd0, 1'b0, 3'd0);
    idle_bus();
    @(posedge clk_i); #1;
    clear_model();
    rst_i = 1'b0;
    chk("rst_ready", mem_ready_o, 0);
    chk("rst_req", data_req_o, 0);
    chk("rst_res_valid", mem_result_valid_o, 0);
    chk("rst_res_id", mem_result_id_o, 0);
    chk("rst_res_rdata", mem_result_rdata_o, 0);
  endtask

  initial begin
    results_seen = 0;
    clear_model();
    @(posedge clk_i); #1;
    do_reset();
    step();

    // Aligned word load, immediate grant, later response.
    set_req(1, 4'd3, 32'h100, 0, 3'd2); data_gnt_i = 1; step();
    chk("load_accepted", last_rdy, 1);
    set_req(0, 0, 0, 0, 0); data_gnt_i = 0; step();
    data_rvalid_i = 1; data_rdata_i = 32'hDEADBEEF; step();
    data_rvalid_i = 0; step();

    // Misaligned halfword store: exception, no bus activity, no result.
    set_req(1, 4'd7, 32'h101, 1, 3'd1); data_gnt_i = 1; step();
    set_req(0, 0, 0, 0, 0); data_gnt_i = 0; step();
    chk("no_outstanding_after_exc", outstanding.size(), 0);

    // Grant withheld for three cycles.
    set_req(1, 4'd9, 32'h2000, 0, 3'd2);
    repeat (3) step();
    data_gnt_i = 1; step();
    set_req(0, 0, 0, 0, 0); data_gnt_i = 0; step();
    chk("one_push_after_wait", outstanding.size(), 1);
    data_rvalid_i = 1; data_rdata_i = 32'h1234_5678; step();
    data_rvalid_i = 0; step();

    // Fill to DEPTH, third request blocked until a slot frees.
    data_gnt_i = 1;
    set_req(1, 4'd1, 32'h300, 0, 3'd2); step();
    set_req(1, 4'd2, 32'h304, 0, 3'd2); step();
    set_req(1, 4'd4, 32'h308, 0, 3'd2); step();
    chk("blocked_when_full", last_rdy, 0);
    data_rvalid_i = 1; data_rdata_i = 32'h1111_0001; step();
    chk("blocked_on_pop_cycle", last_rdy, 0);
    data_rvalid_i = 0; step();
    chk("accepted_after_pop", last_rdy, 1);
    set_req(0, 0, 0, 0, 0); data_gnt_i = 0;
    data_rvalid_i = 1; data_rdata_i = 32'h2222_0002; step();
    data_rdata_i = 32'h4444_0004; step();
    data_rvalid_i = 0; step();

    // Store with bus error.
    set_req(1, 4'd5, 32'h400, 1, 3'd2); data_gnt_i = 1; step();
    set_req(0, 0, 0, 0, 0); data_gnt_i = 0;
    data_rvalid_i = 1; data_rdata_i = 32'hFFFF_FFFF; data_err_i = 1; step();
    data_rvalid_i = 0; data_err_i = 0; step();

    // Reset with one transaction outstanding; late response must be dropped.
    set_req(1, 4'd6, 32'h500, 0, 3'd2); data_gnt_i = 1; step();
    chk("outstanding_before_rst", outstanding.size(), 1);
    do_reset();
    data_rvalid_i = 1; data_rdata_i = 32'hCAFE_F00D; step();
    data_rvalid_i = 0; step();

    // Randomized traffic; request fields held while waiting for ready.
    results_seen = 0;
    for (int i = 0; i < 600; i++) begin
      if (!(mem_valid_i && !last_rdy)) begin
        mem_valid_i  = ($urandom_range(0, 3) != 0);
        mem_size_i   = ($urandom_range(0, 5) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
        mem_addr_i   = $urandom;
        mem_we_i     = 1'($urandom);
        mem_id_i     = 4'($urandom);
        mem_hartid_i = 1'($urandom);
        mem_be_i     = 4'($urandom);
        mem_wdata_i  = $urandom;
      end
      data_gnt_i    = 1'($urandom);
      data_rvalid_i = (outstanding.size() > 0) && ($urandom_range(0, 2) != 0);
      data_rdata_i  = $urandom;
      data_err_i    = ($urandom_range(0, 4) == 0);
      step();
    end
    set_req(0, 0, 0, 0, 0); idle_bus();
    // Drain what is left.
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      data_rvalid_i = (outstanding.size() > 0);
      data_rdata_i  = $urandom;
      step();
    end
    data_rvalid_i = 0; step();
    chk("drained", outstanding.size(), 0);
    chk("random_results_nonzero", results_seen > 0, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Absolute time bound so the run always terminates.
  initial begin
    #500000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
